// File: rtl/pipeline_control_unit.sv
// Control sequencer and hazard unit for the 5-stage RV32I pipeline.
// Carries decoded control through E/M/W and drives the forwarding, stall and flush signals.
module pipeline_control_unit #(
    parameter int REG_AW   = 5,
    parameter int ALUCTL_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RegWriteD,
    input  logic [1:0]          ResultSrcD,
    input  logic                MemWriteD,
    input  logic                BranchD,
    input  logic                JumpD,
    input  logic                jalrD,
    input  logic                ALUSrcD,
    input  logic [ALUCTL_W-1:0] ALUControlD,
    input  logic [2:0]          funct3D,
    input  logic [REG_AW-1:0]   Rs1D,
    input  logic [REG_AW-1:0]   Rs2D,
    input  logic [REG_AW-1:0]   RdD,
    input  logic                ZeroE,
    output logic                ALUSrcE,
    output logic                jalrE,
    output logic [ALUCTL_W-1:0] ALUControlE,
    output logic                PCSrcE,
    output logic                MemWriteM,
    output logic                RegWriteW,
    output logic [1:0]          ResultSrcW,
    output logic [1:0]          ForwardAE,
    output logic [1:0]          ForwardBE,
    output logic                StallF,
    output logic                StallD,
    output logic                FlushD,
    output logic                FlushE,
    output logic                clear,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic                reg_write;
        logic [1:0]          result_src;
        logic                mem_write;
        logic                branch;
        logic                jump;
        logic                jalr;
        logic                alu_src;
        logic [ALUCTL_W-1:0] alu_control;
        logic                bne;
        logic                brvalid;
        logic [REG_AW-1:0]   rs1;
        logic [REG_AW-1:0]   rs2;
        logic [REG_AW-1:0]   rd;
    } ex_t;

    typedef struct packed {
        logic              reg_write;
        logic [1:0]        result_src;
        logic              mem_write;
        logic [REG_AW-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic              reg_write;
        logic [1:0]        result_src;
        logic [REG_AW-1:0] rd;
    } wb_t;

    state_t state, next_state;
    ex_t    ex, ex_next;
    mem_t   mem;
    wb_t    wb;
    logic   lw_stall;
    logic   redirect;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              m_write,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_write,
        input logic [REG_AW-1:0] w_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_write && (m_rd != '0) && (m_rd == src))
            sel = 2'b10;
        else if (w_write && (w_rd != '0) && (w_rd == src))
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        ex_next             = '0;
        ex_next.reg_write   = RegWriteD;
        ex_next.result_src  = ResultSrcD;
        ex_next.mem_write   = MemWriteD;
        ex_next.branch      = BranchD;
        ex_next.jump        = JumpD;
        ex_next.jalr        = jalrD;
        ex_next.alu_src     = ALUSrcD;
        ex_next.alu_control = ALUControlD;
        ex_next.bne         = (funct3D == 3'b001);
        ex_next.brvalid     = (funct3D[2:1] == 2'b00);
        ex_next.rs1         = Rs1D;
        ex_next.rs2         = Rs2D;
        ex_next.rd          = RdD;
    end

    // Only beq/bne carry brvalid, so other branch funct3 values never redirect.
    assign redirect = ex.jump | (ex.branch & ex.brvalid & (ZeroE ^ ex.bne));
    assign lw_stall = (ex.result_src == 2'b01) && (ex.rd != '0) &&
                      ((ex.rd == Rs1D) || (ex.rd == Rs2D));

    always_comb begin
        next_state = state;
        clear      = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        PCSrcE     = 1'b0;
        case (state)
            INIT: begin
                next_state = RUN;
                clear      = 1'b1;
                FlushD     = 1'b1;
                FlushE     = 1'b1;
            end
            RUN: begin
                PCSrcE = redirect;
                StallF = lw_stall & ~redirect;
                StallD = lw_stall & ~redirect;
                FlushD = redirect;
                FlushE = lw_stall | redirect;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= INIT;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
        end else begin
            ex             <= FlushE ? '0 : ex_next;
            mem.reg_write  <= ex.reg_write;
            mem.result_src <= ex.result_src;
            mem.mem_write  <= ex.mem_write;
            mem.rd         <= ex.rd;
            wb.reg_write   <= mem.reg_write;
            wb.result_src  <= mem.result_src;
            wb.rd          <= mem.rd;
        end
    end

    // Counters saturate rather than wrap so long runs never read back as small values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state == RUN) begin
            if (StallD && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (PCSrcE && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign ForwardAE   = fwd_sel(ex.rs1, mem.reg_write, mem.rd, wb.reg_write, wb.rd);
    assign ForwardBE   = fwd_sel(ex.rs2, mem.reg_write, mem.rd, wb.reg_write, wb.rd);
    assign ALUSrcE     = ex.alu_src;
    assign jalrE       = ex.jalr;
    assign ALUControlE = ex.alu_control;
    assign MemWriteM   = mem.mem_write;
    assign RegWriteW   = wb.reg_write;
    assign ResultSrcW  = wb.result_src;

endmodule
